// File: rtl/arb_mux_n_pkg.sv
// Shared constants and helpers for the arbitrated N:1 mux.
// The arbitration mode encoding and the select-width function live here so all files agree.
package arb_mux_n_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } arb_mode_e;

  // Index width for n channels, never below one bit so N=1 still has a select port.
  function automatic int sel_width(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/arb_mux_n_if.sv
// Producer/consumer bundle for arb_mux_n: N request channels in, one registered stream out.
// The slave modport is the mux's view; master is the view of whoever drives and consumes it.
interface arb_mux_n_if
  import arb_mux_n_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 32
);
  localparam int SELW = sel_width(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready
  );
endinterface

// File: rtl/arb_mux_n_rr_arbiter.sv
// Channel arbiter: fixed priority or round-robin grant, combinational from requests and pointer.
// Owns the round-robin pointer, which moves only when the granted word is actually taken.
module rr_arbiter
  import arb_mux_n_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = ARB_RR,
  localparam int SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    i_valid,
  input  logic            i_advance,
  output logic [N-1:0]    o_grant,
  output logic [SELW-1:0] o_grant_idx
);

  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] w_base;
  logic [SELW-1:0] w_idx;
  logic [SELW-1:0] w_cand;
  logic            w_found;

  function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] b, input int k);
    int s;
    s = int'(b) + k;
    if (s >= N) s = s - N;
    return SELW'(s);
  endfunction

  assign w_base = (MODE == ARB_RR) ? r_ptr : '0;

  // Scan from the base upward with wrap; the first requester found wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = wrap_idx(w_base, k);
      if (!w_found && i_valid[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_grant
      assign o_grant[gi] = w_found && (w_idx == SELW'(gi));
    end
  endgenerate

  assign o_grant_idx = w_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && (N > 1)) begin
      r_ptr <= (w_idx == SELW'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-input arbitrated mux with a registered valid/ready output stage.
// The output register refills on the same edge it drains, so throughput is one word per cycle.
module arb_mux_n
  import arb_mux_n_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int MODE  = ARB_RR,
  localparam int SELW = sel_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  arb_mux_n_if.slave    bus
);

  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_grant_idx;
  logic             w_load_en;
  logic             w_any;
  logic             w_transfer;
  logic [WIDTH-1:0] w_chan [N];
  logic [WIDTH-1:0] w_sel_data;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_sel;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign w_chan[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (bus.in_valid),
    .i_advance   (w_transfer),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign w_load_en  = !r_out_valid || bus.out_ready;
  assign w_any      = |w_grant;
  assign w_transfer = w_any && w_load_en && rst_n;
  assign w_sel_data = w_chan[w_grant_idx];

  // out_ready reaches in_ready combinationally so a draining register can accept immediately.
  assign bus.in_ready = w_grant & {N{w_load_en && rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_load_en) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_grant_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: a round-robin and a fixed-priority instance side by side.
// Covers reset, fairness, priority, backpressure, wrap/skip, idle and asynchronous reset.
module tb_arb_mux_n;
  import arb_mux_n_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  arb_mux_n_if #(.N(4), .WIDTH(32)) if_rr ();
  arb_mux_n_if #(.N(4), .WIDTH(32)) if_fp ();

  arb_mux_n #(.N(4), .WIDTH(32), .MODE(ARB_RR)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_rr)
  );

  arb_mux_n #(.N(4), .WIDTH(32), .MODE(ARB_FIXED)) u_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rr_data(input logic [31:0] d2);
    if_rr.in_data = {32'hA3, d2, 32'hA1, 32'hA0};
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    if_rr.in_valid  = 4'hF;
    if_rr.out_ready = 1'b1;
    set_rr_data(32'hA2);
    if_fp.in_valid  = 4'hF;
    if_fp.out_ready = 1'b1;
    if_fp.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

    // Reset held with every channel requesting.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(if_rr.out_valid), 32'd0);
    chk("rst_out_data",  if_rr.out_data, 32'd0);
    chk("rst_out_sel",   32'(if_rr.out_sel), 32'd0);
    chk("rst_in_ready",  32'(if_rr.in_ready), 32'd0);
    chk("rst_fp_ready",  32'(if_fp.in_ready), 32'd0);

    #2 rst_n = 1'b1;
    if_fp.in_valid = 4'b1010;
    #1;
    chk("rel_rr_ready", 32'(if_rr.in_ready), 32'h1);

    // Round-robin fairness alongside fixed priority on 4'b1010.
    for (int i = 0; i < 5; i++) begin
      chk("fp_ready", 32'(if_fp.in_ready), 32'h2);
      step();
      chk("rr_sel",   32'(if_rr.out_sel), 32'(i % 4));
      chk("rr_data",  if_rr.out_data, 32'hA0 + 32'(i % 4));
      chk("rr_valid", 32'(if_rr.out_valid), 32'd1);
      chk("fp_sel",   32'(if_fp.out_sel), 32'd1);
      chk("fp_data",  if_fp.out_data, 32'hA1);
    end
    // ptr is now 1; load DEAD_BEEF from channel 2, leaving ptr at 3.
    set_rr_data(32'hDEAD_BEEF);
    if_rr.in_valid = 4'b0100;
    step();
    chk("bp_load_sel",  32'(if_rr.out_sel), 32'd2);
    chk("bp_load_data", if_rr.out_data, 32'hDEAD_BEEF);

    // Backpressure for 5 cycles with every channel requesting.
    set_rr_data(32'hA2);
    if_rr.in_valid  = 4'hF;
    if_rr.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 32'(if_rr.in_ready), 32'd0);
      step();
      chk("bp_valid", 32'(if_rr.out_valid), 32'd1);
      chk("bp_data",  if_rr.out_data, 32'hDEAD_BEEF);
      chk("bp_sel",   32'(if_rr.out_sel), 32'd2);
    end

    // Release: drain and reload on one edge; only channel 2 asks so ptr stays at 3.
    if_rr.in_valid  = 4'b0100;
    if_rr.out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(if_rr.in_ready), 32'h4);
    step();
    chk("bp_rel_sel",  32'(if_rr.out_sel), 32'd2);
    chk("bp_rel_data", if_rr.out_data, 32'hA2);
    chk("bp_rel_vld",  32'(if_rr.out_valid), 32'd1);

    // Wrap and skip from ptr=3 with channels 0 and 2 requesting.
    if_rr.in_valid = 4'b0101;
    #1;
    chk("wrap_ready", 32'(if_rr.in_ready), 32'h1);
    step();
    chk("wrap_sel",  32'(if_rr.out_sel), 32'd0);
    chk("wrap_data", if_rr.out_data, 32'hA0);
    #1;
    chk("skip_ready", 32'(if_rr.in_ready), 32'h4);
    step();
    chk("skip_sel",  32'(if_rr.out_sel), 32'd2);
    chk("skip_data", if_rr.out_data, 32'hA2);

    // Idle with a drain: valid drops, data and select hold.
    if_rr.in_valid = 4'b0000;
    step();
    chk("idle_valid", 32'(if_rr.out_valid), 32'd0);
    chk("idle_data",  if_rr.out_data, 32'hA2);
    chk("idle_sel",   32'(if_rr.out_sel), 32'd2);

    // Async reset while a word is held (ptr=3 before, 2 after this load).
    if_rr.in_valid = 4'b0010;
    step();
    chk("ar_pre_sel", 32'(if_rr.out_sel), 32'd1);
    if_rr.in_valid  = 4'b0000;
    if_rr.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(if_rr.out_valid), 32'd0);
    chk("ar_data",  if_rr.out_data, 32'd0);
    #1 rst_n = 1'b1;
    if_rr.in_valid  = 4'hF;
    if_rr.out_ready = 1'b1;
    #1;
    chk("ar_ptr_ready", 32'(if_rr.in_ready), 32'h1);
    step();
    chk("ar_post_sel",  32'(if_rr.out_sel), 32'd0);
    chk("ar_post_data", if_rr.out_data, 32'hA0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
